// File: rtl/viterbi_pkg.sv
// Shared helpers for the hard-decision rate-1/2 Viterbi decoder: encoder model,
// branch-metric popcount and trellis sizing.
package viterbi_pkg;

  localparam int K_MAX  = 7;
  localparam int NS_MAX = 1 << (K_MAX - 1);

  function automatic int f_ns(input int k);
    return 1 << (k - 1);
  endfunction

  function automatic int f_metric_sat(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic logic f_parity(input logic [K_MAX-1:0] v);
    return ^v;
  endfunction

  function automatic logic [1:0] f_popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

  // State and generator are zero-extended to K_MAX, so the AND ignores unused high bits.
  function automatic logic f_enc_out(input logic [K_MAX-2:0] state, input logic b,
                                     input logic [K_MAX-1:0] poly);
    return f_parity({state, b} & poly);
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: two saturating candidates, the
// smaller wins and ties go to predecessor x = 0.
module viterbi_acs
  import viterbi_pkg::*;
#(
  parameter int P_METRIC_W = 6
) (
  input  logic [P_METRIC_W-1:0] pm0_i,
  input  logic [1:0]            bm0_i,
  input  logic [P_METRIC_W-1:0] pm1_i,
  input  logic [1:0]            bm1_i,
  output logic [P_METRIC_W-1:0] pm_o,
  output logic                  dec_o
);

  localparam logic [P_METRIC_W:0] SAT = (P_METRIC_W+1)'(f_metric_sat(P_METRIC_W));

  function automatic logic [P_METRIC_W-1:0] f_sat_add(input logic [P_METRIC_W-1:0] pm,
                                                      input logic [1:0] bm);
    logic [P_METRIC_W:0] sum;
    sum = {1'b0, pm} + {{(P_METRIC_W-1){1'b0}}, bm};
    return (sum > SAT) ? SAT[P_METRIC_W-1:0] : sum[P_METRIC_W-1:0];
  endfunction

  logic [P_METRIC_W-1:0] cand0, cand1;

  assign cand0 = f_sat_add(pm0_i, bm0_i);
  assign cand1 = f_sat_add(pm1_i, bm1_i);
  assign dec_o = (cand1 < cand0);
  assign pm_o  = dec_o ? cand1 : cand0;

endmodule

// File: rtl/viterbi_rx_decoder.sv
// Full-trellis hard-decision Viterbi decoder with erasure masks, per-symbol
// metric normalisation and register-exchange survivors.
module viterbi_rx_decoder
  import viterbi_pkg::*;
#(
  parameter int             P_K           = 3,
  parameter logic [P_K-1:0] P_POLY_0      = 3'b111,
  parameter logic [P_K-1:0] P_POLY_1      = 3'b101,
  parameter int             P_DEPTH       = 15,
  parameter int             P_METRIC_W    = 6,
  parameter int             P_START_STATE = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [1:0]            i_data,
  input  logic [1:0]            i_valid,
  output logic                  o_data,
  output logic                  o_valid,
  output logic                  o_error,
  output logic [P_METRIC_W-1:0] o_metric
);

  localparam int NS = f_ns(P_K);
  localparam int SW = P_K - 1;
  localparam int FW = $clog2(P_DEPTH + 1);
  localparam logic [K_MAX-1:0]      POLY0_X = K_MAX'(P_POLY_0);
  localparam logic [K_MAX-1:0]      POLY1_X = K_MAX'(P_POLY_1);
  localparam logic [P_METRIC_W-1:0] PM_INIT = P_METRIC_W'(1 << (P_METRIC_W - 2));
  localparam logic [FW-1:0]         FILL_MAX = FW'(P_DEPTH);

  logic [P_METRIC_W-1:0] pm_q [NS];
  logic [P_METRIC_W-1:0] pm_acs [NS];
  logic [P_METRIC_W-1:0] pm_d [NS];
  logic [P_DEPTH-1:0]    surv_q [NS];
  logic [P_DEPTH-1:0]    surv_d [NS];
  logic [SW-1:0]         pred [NS];
  logic [NS-1:0]         dec;
  logic [FW-1:0]         fill_q, fill_d;
  logic [P_METRIC_W-1:0] min_pm;
  logic [SW-1:0]         best;
  logic                  acc;
  logic                  o_data_q, o_valid_q, o_error_q;
  logic [P_METRIC_W-1:0] o_metric_q;

  assign acc = |i_valid;

  for (genvar n = 0; n < NS; n++) begin : g_state
    localparam int PA = n >> 1;
    localparam int PB = (n >> 1) | (1 << (P_K - 2));
    localparam logic B = 1'(n % 2);
    localparam logic [1:0] CA = {f_enc_out((K_MAX-1)'(PA), B, POLY1_X),
                                 f_enc_out((K_MAX-1)'(PA), B, POLY0_X)};
    localparam logic [1:0] CB = {f_enc_out((K_MAX-1)'(PB), B, POLY1_X),
                                 f_enc_out((K_MAX-1)'(PB), B, POLY0_X)};

    logic [1:0] bm_a, bm_b;
    // Erased code bits are masked out before the Hamming count.
    assign bm_a = f_popcount2((i_data ^ CA) & i_valid);
    assign bm_b = f_popcount2((i_data ^ CB) & i_valid);

    viterbi_acs #(.P_METRIC_W(P_METRIC_W)) u_acs (
      .pm0_i (pm_q[PA]),
      .bm0_i (bm_a),
      .pm1_i (pm_q[PB]),
      .bm1_i (bm_b),
      .pm_o  (pm_acs[n]),
      .dec_o (dec[n])
    );

    assign pred[n]   = dec[n] ? SW'(PB) : SW'(PA);
    assign surv_d[n] = (surv_q[pred[n]] << 1) | P_DEPTH'(B);
  end

  always_comb begin
    min_pm = pm_acs[0];
    best   = '0;
    for (int n = 1; n < NS; n++) begin
      if (pm_acs[n] < min_pm) begin
        min_pm = pm_acs[n];
        best   = SW'(n);
      end
    end
    for (int n = 0; n < NS; n++) pm_d[n] = pm_acs[n] - min_pm;
  end

  assign fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);

  // ---- single register stage: metrics, survivors and output qualifiers ----
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int n = 0; n < NS; n++) begin
        pm_q[n]   <= (n == P_START_STATE) ? '0 : PM_INIT;
        surv_q[n] <= '0;
      end
      fill_q     <= '0;
      o_data_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_error_q  <= 1'b0;
      o_metric_q <= '0;
    end else begin
      o_valid_q <= 1'b0;
      o_error_q <= 1'b0;
      if (acc) begin
        pm_q       <= pm_d;
        surv_q     <= surv_d;
        fill_q     <= fill_d;
        o_valid_q  <= (fill_d == FILL_MAX);
        o_data_q   <= surv_d[best][P_DEPTH-1];
        o_error_q  <= (min_pm != '0);
        o_metric_q <= min_pm;
      end
    end
  end

  assign o_data   = o_data_q;
  assign o_valid  = o_valid_q;
  assign o_error  = o_error_q;
  assign o_metric = o_metric_q;

endmodule

// File: tb/tb_viterbi_rx_decoder.sv
// Scoreboard bench: drivers push the transmitted message bit expected for each
// accepted symbol; monitors pop and compare whenever the decoder presents a bit.
module tb_viterbi_rx_decoder;

  localparam int D1 = 15;
  localparam int D2 = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, rst2 = 1'b1;
  logic [1:0] d1 = '0, v1 = '0, d2 = '0, v2 = '0;
  logic       od1, ov1, oe1, od2, ov2, oe2;
  logic [5:0] om1;
  logic [7:0] om2;

  viterbi_rx_decoder u_dut (
    .i_clk(clk), .i_reset(rst1), .i_data(d1), .i_valid(v1),
    .o_data(od1), .o_valid(ov1), .o_error(oe1), .o_metric(om1)
  );

  viterbi_rx_decoder #(
    .P_K(7), .P_POLY_0(7'o171), .P_POLY_1(7'o133), .P_DEPTH(D2), .P_METRIC_W(8)
  ) u_dut_k7 (
    .i_clk(clk), .i_reset(rst2), .i_data(d2), .i_valid(v2),
    .o_data(od2), .o_valid(ov2), .o_error(oe2), .o_metric(om2)
  );

  int checks = 0, errors = 0;
  bit msg1[$], msg2[$], exp1[$], exp2[$];
  int sym1 = 0, sym2 = 0, nout1 = 0, epulse1 = 0, nbits2 = 0, biterr2 = 0;
  logic [5:0] emet1 = '0;
  logic acc1_q = 1'b0;
  bit e1, e2;

  always @(posedge clk) acc1_q <= (v1 != 2'b00) && !rst1;

  // Monitor for the default-parameter decoder.
  always @(negedge clk) begin
    if (ov1) nout1++;
    if (exp1.size() > 0) begin
      e1 = exp1.pop_front();
      checks++;
      if (!ov1 || od1 !== e1 || !acc1_q) begin
        errors++;
        $display("FAIL dec1_bit: o_valid=%0b o_data=%0b accepted=%0b, required o_valid=1 o_data=%0b accepted=1",
                 ov1, od1, acc1_q, e1);
      end
    end else if (ov1 !== 1'b0) begin
      checks++; errors++;
      $display("FAIL dec1_spurious_valid: o_valid=%0b, required 0", ov1);
    end
    if (oe1) begin
      epulse1++;
      emet1 = om1;
      checks++;
      if (!acc1_q || om1 == 6'd0 || om1 > 6'd2) begin
        errors++;
        $display("FAIL dec1_error_pulse: accepted=%0b o_metric=%0d, required accepted=1 metric 1..2",
                 acc1_q, om1);
      end
    end
  end

  // Monitor for the K=7 decoder: bit errors feed the BER check.
  always @(negedge clk) begin
    if (exp2.size() > 0) begin
      e2 = exp2.pop_front();
      if (!ov2) begin
        checks++; errors++;
        $display("FAIL dec2_valid: o_valid=%0b, required 1", ov2);
      end else begin
        nbits2++;
        if (od2 !== e2) biterr2++;
      end
    end else if (ov2 !== 1'b0) begin
      checks++; errors++;
      $display("FAIL dec2_spurious_valid: o_valid=%0b, required 0", ov2);
    end
    if (oe2 && om2 > 8'd2) begin
      checks++; errors++;
      $display("FAIL dec2_metric: o_metric=%0d, required <= 2", om2);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic encode(input int k, input logic [6:0] p0, input logic [6:0] p1,
                        input logic b, inout int sr, output logic [1:0] c);
    logic [6:0] r;
    r  = 7'(((sr << 1) | int'(b)) & ((1 << k) - 1));
    c  = {^(r & p1), ^(r & p0)};
    sr = int'(r) & ((1 << (k - 1)) - 1);
  endtask

  task automatic send1(input logic [1:0] d, input logic [1:0] v);
    @(negedge clk);
    d1 = d; v1 = v;
    @(posedge clk);
    if (v != 2'b00) begin
      sym1++;
      if (sym1 >= D1) exp1.push_back(msg1[sym1 - D1]);
    end
  endtask

  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) send1(2'($urandom), 2'b00);
  endtask

  task automatic reset1(input logic [1:0] d, input logic [1:0] v);
    @(negedge clk);
    rst1 = 1'b1; d1 = d; v1 = v;
    @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; v1 = 2'b00;
    sym1 = 0; nout1 = 0; epulse1 = 0;
  endtask

  task automatic send2(input logic [1:0] d);
    @(negedge clk);
    d2 = d; v2 = 2'b11;
    @(posedge clk);
    sym2++;
    if (sym2 >= D2) exp2.push_back(msg2[sym2 - D2]);
  endtask

  // Scenario-1 stream: bits 1,0,1,1,0,0 then 20 zero-pairs; optional gaps/error.
  task automatic run_s1(input bit gaps, input int err_sym);
    logic [1:0] tbl [6];
    logic [1:0] dd;
    tbl = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
    msg1 = {};
    for (int i = 0; i < 26; i++) msg1.push_back(i < 6 ? ((6'b001101 >> i) & 1) : 1'b0);
    for (int i = 0; i < 26; i++) begin
      dd = (i < 6) ? tbl[i] : 2'b00;
      if (i + 1 == err_sym) dd = 2'b01;
      send1(dd, 2'b11);
      if (gaps) idle1(1 + i % 3);
    end
    idle1(3);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] punct [3];
    logic [1:0] c;
    int sr;
    punct = '{2'b11, 2'b01, 2'b10};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    chk("reset_o_valid", int'(ov1), 0);
    chk("reset_o_data", int'(od1), 0);
    chk("reset_o_error", int'(oe1), 0);
    chk("reset_o_metric", int'(om1), 0);

    // 1: clean stream
    run_s1(1'b0, 0);
    chk("s1_outputs", nout1, 12);
    chk("s1_error_pulses", epulse1, 0);
    chk("s1_drain", exp1.size(), 0);

    // 2: single channel error on symbol 3
    reset1(2'b00, 2'b00);
    run_s1(1'b0, 3);
    chk("s2_outputs", nout1, 12);
    chk("s2_error_pulses", epulse1, 1);
    chk("s2_error_metric", int'(emet1), 1);

    // 3: punctured 200-bit random message, garbage on erased bits
    reset1(2'b00, 2'b00);
    msg1 = {};
    for (int i = 0; i < 200; i++) msg1.push_back(1'($urandom));
    sr = 0;
    for (int i = 0; i < 200; i++) begin
      encode(3, 7'b0000111, 7'b0000101, msg1[i], sr, c);
      send1((c & punct[i % 3]) | (2'($urandom) & ~punct[i % 3]), punct[i % 3]);
    end
    idle1(3);
    chk("s3_outputs", nout1, 200 - D1 + 1);
    chk("s3_error_pulses", epulse1, 0);
    chk("s3_drain", exp1.size(), 0);

    // 4: idle gaps between symbols
    reset1(2'b00, 2'b00);
    run_s1(1'b1, 0);
    chk("s4_outputs", nout1, 12);
    chk("s4_error_pulses", epulse1, 0);

    // 5: reset lands on symbol 10 with a live symbol, then full replay
    reset1(2'b00, 2'b00);
    run_s1(1'b0, 0);
    reset1(2'b00, 2'b00);
    for (int i = 0; i < 9; i++) send1(i < 6 ? 2'b11 : 2'b00, 2'b11);
    reset1(2'b11, 2'b11);
    chk("s5_after_reset_valid", int'(ov1), 0);
    chk("s5_after_reset_metric", int'(om1), 0);
    run_s1(1'b0, 0);
    chk("s5_outputs", nout1, 12);
    chk("s5_drain", exp1.size(), 0);

    // 6: K=7 code, 2% bit-flip channel
    msg2 = {};
    for (int i = 0; i < 600; i++) msg2.push_back(1'($urandom));
    sr = 0;
    for (int i = 0; i < 600; i++) begin
      encode(7, 7'o171, 7'o133, msg2[i], sr, c);
      if ($urandom_range(0, 99) < 2) c[0] = ~c[0];
      if ($urandom_range(0, 99) < 2) c[1] = ~c[1];
      send2(c);
    end
    @(negedge clk);
    v2 = 2'b00;
    repeat (3) @(negedge clk);
    chk("s6_outputs", nbits2, 600 - D2 + 1);
    chk("s6_ber_below_1e-3", int'(biterr2 * 1000 < nbits2), 1);
    chk("s6_drain", exp2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
